// File: rtl/nios_jtag_pkg.sv
// Shared definitions for the Nios debug-side JTAG scan master.
//   DR_WIDTH_DEFAULT : default debug data-register scan length in bits
//   IR_WIDTH         : width of the virtual IR (ir_in)
//   jtag_state_e     : scan master FSM states
package nios_jtag_pkg;

    localparam int DR_WIDTH_DEFAULT = 38;
    localparam int IR_WIDTH         = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RSP  = 3'd5
    } jtag_state_e;

endpackage

// File: rtl/nios_jtag_tck_gen.sv
// tck divider for the scan master.
// tck is low for TCK_DIV clk cycles, then high for TCK_DIV clk cycles, while
// run_i is high; it is held low (and the divider cleared) otherwise.
// Ports:
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   run_i      : enable tck generation
//   tck_o      : generated test clock (registered)
//   rise_en_o  : one-clk pulse; tck goes 0->1 at the end of this cycle
//   fall_en_o  : one-clk pulse; tck goes 1->0 at the end of this cycle
module nios_jtag_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic tck_o,
    output logic rise_en_o,
    output logic fall_en_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       tck_q, tck_d;
    logic       last;

    assign last = (cnt_q == 8'(TCK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!run_i) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (last) begin
            cnt_d = '0;
            tck_d = ~tck_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    // Pulses coincide with the clk edge that toggles tck, so logic clocked by
    // clk sees "tck edge" and the new tck level on the same edge.
    assign rise_en_o = run_i && last && !tck_q;
    assign fall_en_o = run_i && last &&  tck_q;
    assign tck_o     = tck_q;

endmodule

// File: rtl/nios_jtag_scan_master.sv
// Nios JTAG debug scan master.
// Accepts a command (virtual IR + DR word), walks UIR -> CDR -> SDR -> UDR on
// a divided tck, shifts the DR LSB first on tdi while capturing tdo, and
// returns the captured word as a response.
// Ports:
//   clk, reset_n                   : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_ir/cmd_dr : command handshake and payload
//   rsp_valid/rsp_ready/rsp_dr     : response handshake and captured data
//   abort                          : cancel the scan in UIR/CDR/SDR
//   tck, tdi, tdo                  : debug scan clock and data
//   ir_in, vs_uir/cdr/sdr/udr      : virtual JTAG IR and state strobes
//   jtag_state_rti                 : high while idle
module nios_jtag_scan_master
    import nios_jtag_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DR_WIDTH_DEFAULT,
    parameter int unsigned TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    input  logic                abort,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam int CNT_W = $clog2(DR_WIDTH + 1);

    jtag_state_e         state_q, state_d;
    logic [DR_WIDTH-1:0] sr_q;
    logic [DR_WIDTH-1:0] rsp_dr_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic                tdi_q;
    logic                abort_pend_q, abort_pend_d;
    logic                run, rise_en, fall_en;
    logic                abortable, abort_now;

    assign run       = (state_q != ST_IDLE) && (state_q != ST_RSP);
    assign abortable = (state_q == ST_UIR) || (state_q == ST_CDR) || (state_q == ST_SDR);
    assign abort_now = abortable && (abort || abort_pend_q);

    nios_jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .run_i     (run),
        .tck_o     (tck),
        .rise_en_o (rise_en),
        .fall_en_o (fall_en)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_UIR;
            ST_UIR:  if (fall_en) state_d = abort_now ? ST_IDLE : ST_CDR;
            ST_CDR:  if (fall_en) state_d = abort_now ? ST_IDLE : ST_SDR;
            // The counter hits 0 on the last rising edge; leave on the fall after it.
            ST_SDR: begin
                if (fall_en && abort_now)              state_d = ST_IDLE;
                else if (fall_en && bit_cnt_q == '0)   state_d = ST_UDR;
            end
            ST_UDR:  if (fall_en) state_d = ST_RSP;
            ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // An abort is remembered until the falling edge that ends the current tck
    // period; it is dropped once the FSM leaves the abortable states.
    always_comb begin
        abort_pend_d = 1'b0;
        if ((state_d == ST_UIR) || (state_d == ST_CDR) || (state_d == ST_SDR))
            abort_pend_d = abort_pend_q || (abort && abortable);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            rsp_dr_q     <= '0;
            bit_cnt_q    <= '0;
            ir_q         <= '0;
            tdi_q        <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            abort_pend_q <= abort_pend_d;
            if (state_q == ST_IDLE && cmd_valid) begin
                ir_q <= cmd_ir;
                sr_q <= cmd_dr;
            end
            if (fall_en)
                tdi_q <= sr_q[0];
            if (state_q == ST_SDR && rise_en) begin
                sr_q      <= {tdo, sr_q[DR_WIDTH-1:1]};
                bit_cnt_q <= bit_cnt_q - CNT_W'(1);
            end
            if (state_q == ST_CDR && state_d == ST_SDR)
                bit_cnt_q <= CNT_W'(DR_WIDTH);
            if (state_q == ST_UDR && state_d == ST_RSP)
                rsp_dr_q <= sr_q;
        end
    end

    assign cmd_ready      = (state_q == ST_IDLE);
    assign jtag_state_rti = (state_q == ST_IDLE);
    assign rsp_valid      = (state_q == ST_RSP);
    assign rsp_dr         = rsp_dr_q;
    assign tdi            = tdi_q;
    assign ir_in          = ir_q;
    assign vs_uir         = (state_q == ST_UIR);
    assign vs_cdr         = (state_q == ST_CDR);
    assign vs_sdr         = (state_q == ST_SDR);
    assign vs_udr         = (state_q == ST_UDR);

endmodule

// File: tb/tb_nios_jtag_scan_master.sv
// Bench for nios_jtag_scan_master: instance A (TCK_DIV=2) runs directed and
// randomized scans with loopback / random / all-ones tdo, abort, response
// back-pressure and mid-scan reset; instance B (TCK_DIV=1) runs back-to-back
// commands. Expected data is built from the tdo bits seen on each SDR tck rise.
module tb_nios_jtag_scan_master;
    localparam int DR     = 38;
    localparam int DIV_A  = 2;
    localparam int DIV_B  = 1;
    localparam int SCAN_A = (3 + DR) * 2 * DIV_A;
    localparam int SCAN_B = (3 + DR) * 2 * DIV_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DR-1:0] rand_dr();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return w[DR-1:0];
    endfunction

    // ---------------- instance A ----------------
    logic          rst_a, cmd_valid_a, cmd_ready_a, rsp_valid_a, rsp_ready_a, abort_a;
    logic [1:0]    cmd_ir_a, ir_in_a;
    logic [DR-1:0] cmd_dr_a, rsp_dr_a;
    logic          tck_a, tdi_a, tdo_a, vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a, rti_a;
    int            tdo_mode = 0;   // 0 loopback, 1 random, 2 ones
    logic          tdo_rnd = 1'b0;

    assign tdo_a = (tdo_mode == 0) ? tdi_a : (tdo_mode == 1) ? tdo_rnd : 1'b1;

    nios_jtag_scan_master #(.DR_WIDTH(DR), .TCK_DIV(DIV_A)) dut_a (
        .clk(clk), .reset_n(rst_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_ir(cmd_ir_a), .cmd_dr(cmd_dr_a), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
        .rsp_dr(rsp_dr_a), .abort(abort_a), .tck(tck_a), .tdi(tdi_a), .tdo(tdo_a),
        .ir_in(ir_in_a), .vs_uir(vs_uir_a), .vs_cdr(vs_cdr_a), .vs_sdr(vs_sdr_a),
        .vs_udr(vs_udr_a), .jtag_state_rti(rti_a)
    );

    initial forever begin
        @(negedge clk);
        tdo_rnd = 1'($urandom_range(0, 1));
    end

    logic sdr_tdo_q[$];
    logic sdr_tdi_q[$];
    int   sdr_rises = 0;
    bit   udr_seen  = 0;

    always @(posedge tck_a) if (vs_sdr_a) begin
        sdr_tdo_q.push_back(tdo_a);
        sdr_tdi_q.push_back(tdi_a);
        sdr_rises++;
    end
    always @(posedge clk) if (vs_udr_a) udr_seen = 1;

    // Called and returns at a clk negedge. evt: 0 none, 1 abort, 2 reset,
    // fired after evt_at SDR tck rises. hold: cycles rsp_ready is kept low
    // while a following command is already presented.
    task automatic scan_a(input logic [1:0] ir, input logic [DR-1:0] dr, input int mode,
                          input int evt, input int evt_at, input int hold);
        logic [DR-1:0] exp_dr, tdi_word;
        int cyc, ev_cyc, g, stable_bad, ready_bad;
        bit fired, rsp_seen;
        tdo_mode = mode;
        cmd_ir_a = ir; cmd_dr_a = dr; cmd_valid_a = 1'b1;
        g = 0;
        while (!cmd_ready_a && g < 500) begin @(negedge clk); g++; end
        chk("a_cmd_ready", cmd_ready_a, 1);
        @(posedge clk);
        sdr_tdo_q.delete(); sdr_tdi_q.delete(); sdr_rises = 0; udr_seen = 0;
        @(negedge clk);
        cmd_valid_a = 1'b0;
        chk("a_ir_in", ir_in_a, ir);
        cmd_ir_a = ~ir; cmd_dr_a = ~dr;   // must be ignored mid-scan
        fired = 0; ev_cyc = 0;
        for (cyc = 1; cyc <= SCAN_A + 20; cyc++) begin
            @(posedge clk); @(negedge clk);
            abort_a = 1'b0;
            if (rsp_valid_a || (fired && rti_a)) break;
            if (evt != 0 && !fired && sdr_rises == evt_at) begin
                fired = 1; ev_cyc = cyc;
                if (evt == 1) abort_a = 1'b1;
                else begin
                    rst_a = 1'b0; #1;
                    chk("rst_tck", tck_a, 0);
                    chk("rst_tdi", tdi_a, 0);
                    chk("rst_ir_in", ir_in_a, 0);
                    chk("rst_vs", {vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a}, 0);
                    chk("rst_rti", rti_a, 1);
                    chk("rst_cmd_ready", cmd_ready_a, 1);
                    chk("rst_rsp", {rsp_valid_a, rsp_dr_a}, 0);
                    @(negedge clk);
                    rst_a = 1'b1;
                    g = 0;
                    repeat (4) begin @(negedge clk); if (tck_a !== 1'b0) g++; end
                    chk("rst_no_tck_edge", g, 0);
                    return;
                end
            end
        end
        if (evt == 1) begin
            chk("abort_fired", fired, 1);
            chk("abort_idle", rti_a, 1);
            chk("abort_within_2div", (cyc - ev_cyc) <= 2 * DIV_A, 1);
            rsp_seen = 0;
            repeat (20) begin @(negedge clk); if (rsp_valid_a) rsp_seen = 1; end
            chk("abort_no_rsp", rsp_seen, 0);
            chk("abort_no_udr", udr_seen, 0);
            return;
        end
        // Reference: bit i of the captured word is the i-th tdo sampled in SDR.
        exp_dr = '0; tdi_word = '0;
        for (int i = 0; i < DR && i < sdr_tdo_q.size(); i++) begin
            exp_dr[i]   = sdr_tdo_q[i];
            tdi_word[i] = sdr_tdi_q[i];
        end
        if (mode == 0) exp_dr = dr;
        if (mode == 2) exp_dr = '1;
        chk("rsp_latency", cyc, SCAN_A);
        chk("rsp_valid", rsp_valid_a, 1);
        chk("sdr_rises", sdr_rises, DR);
        chk("tdi_seq", tdi_word, dr);
        chk("rsp_dr", rsp_dr_a, exp_dr);
        chk("udr_seen", udr_seen, 1);
        if (hold > 0) begin
            cmd_valid_a = 1'b1;
            stable_bad = 0; ready_bad = 0;
            repeat (hold) begin
                @(negedge clk);
                if (rsp_dr_a !== exp_dr || !rsp_valid_a) stable_bad++;
                if (cmd_ready_a) ready_bad++;
            end
            chk("hold_rsp_stable", stable_bad, 0);
            chk("hold_cmd_ready_low", ready_bad, 0);
        end
        rsp_ready_a = 1'b1;
        chk("rsp_hs_cmd_ready_low", cmd_ready_a, 0);
        @(negedge clk);
        rsp_ready_a = 1'b0;
        chk("rsp_hs_idle", rti_a, 1);
        chk("rsp_hs_drop", rsp_valid_a, 0);
    endtask

    // ---------------- instance B ----------------
    logic          rst_b, cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b;
    logic [1:0]    cmd_ir_b, ir_in_b;
    logic [DR-1:0] cmd_dr_b, rsp_dr_b;
    logic          tck_b, tdi_b, vs_uir_b, vs_cdr_b, vs_sdr_b, vs_udr_b, rti_b;

    nios_jtag_scan_master #(.DR_WIDTH(DR), .TCK_DIV(DIV_B)) dut_b (
        .clk(clk), .reset_n(rst_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_ir(cmd_ir_b), .cmd_dr(cmd_dr_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_dr(rsp_dr_b), .abort(1'b0), .tck(tck_b), .tdi(tdi_b), .tdo(tdi_b),
        .ir_in(ir_in_b), .vs_uir(vs_uir_b), .vs_cdr(vs_cdr_b), .vs_sdr(vs_sdr_b),
        .vs_udr(vs_udr_b), .jtag_state_rti(rti_b)
    );

    logic [1:0] ir_prev_b  = 2'b00;
    logic       rti_prev_b = 1'b1;
    always @(negedge clk) begin
        if (rst_b && ir_in_b !== ir_prev_b) chk("b_ir_changes_only_in_idle", rti_prev_b, 1);
        ir_prev_b  = ir_in_b;
        rti_prev_b = rti_b;
    end

    // ---------------- sequence ----------------
    initial begin
        logic [DR-1:0] drb;
        logic [1:0]    irb;
        int            g, cyc;
        rst_a = 1'b1; rst_b = 1'b1;
        cmd_valid_a = 0; cmd_ir_a = 0; cmd_dr_a = 0; rsp_ready_a = 0; abort_a = 0;
        cmd_valid_b = 0; cmd_ir_b = 0; cmd_dr_b = 0; rsp_ready_b = 0;
        #1 rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rti", rti_a, 1);
        chk("reset_cmd_ready", cmd_ready_a, 1);
        chk("reset_tck", tck_a, 0);
        chk("reset_rsp_valid", rsp_valid_a, 0);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);

        scan_a(2'b01, 38'h2A_5A5A_5A5A, 0, 0, 0, 0);
        scan_a(2'($urandom()), rand_dr(), 2, 0, 0, 0);
        repeat (3) scan_a(2'($urandom()), rand_dr(), 1, 0, 0, 0);
        scan_a(2'($urandom()), rand_dr(), 0, 1, 10, 0);
        scan_a(2'($urandom()), rand_dr(), 1, 0, 0, 50);
        scan_a(2'($urandom()), rand_dr(), 0, 0, 0, 0);
        scan_a(2'($urandom()), rand_dr(), 0, 2, 5, 0);
        scan_a(2'($urandom()), rand_dr(), 1, 0, 0, 0);

        cmd_valid_b = 1'b1; rsp_ready_b = 1'b1;
        for (int k = 0; k < 2; k++) begin
            irb = (k == 0) ? 2'b10 : 2'b11;
            drb = rand_dr();
            cmd_ir_b = irb; cmd_dr_b = drb;
            g = 0;
            while (!cmd_ready_b && g < 500) begin @(negedge clk); g++; end
            chk("b_cmd_ready", cmd_ready_b, 1);
            @(posedge clk); @(negedge clk);
            chk("b_ir_in", ir_in_b, irb);
            for (cyc = 1; cyc <= SCAN_B + 20; cyc++) begin
                @(posedge clk); @(negedge clk);
                if (rsp_valid_b) break;
            end
            chk("b_latency", cyc, SCAN_B);
            chk("b_rsp_dr", rsp_dr_b, drb);
            if (k == 1) cmd_valid_b = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("b_final_idle", rti_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
